// File: rtl/p65c816_seq_ctrl.sv
// Instruction register and micro-cycle sequencer feeding the 65C816 microcode ROM address {IR, MC}.
// Handles opcode fetch, interrupt/reset injection and the WAI/STP hold states.
module p65c816_seq_ctrl #(
    parameter int unsigned MC_W     = 4,
    parameter bit          NMI_SYNC = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic            RDY,
    input  logic [2:0]      STATE_CTRL,
    input  logic [7:0]      D_IN,
    input  logic            M_FLAG,
    input  logic            X_FLAG,
    input  logic            I_FLAG,
    input  logic            DL_ZERO,
    input  logic            BR_TAKEN,
    input  logic            NMI_N,
    input  logic            IRQ_N,
    output logic [7:0]      IR,
    output logic [MC_W-1:0] MC,
    output logic            OPFETCH,
    output logic            INT_ACT,
    output logic [1:0]      VEC_SEL,
    output logic            WAIT_ST,
    output logic            STOP_ST,
    output logic            MC_OVF
);

    typedef enum logic [2:0] {
        SC_NEXT    = 3'b000,
        SC_LAST    = 3'b001,
        SC_SKIP_M8 = 3'b010,
        SC_SKIP_X8 = 3'b011,
        SC_SKIP_DL = 3'b100,
        SC_BRANCH  = 3'b101,
        SC_WAIT    = 3'b110,
        SC_STOP    = 3'b111
    } stctl_e;

    typedef enum logic [1:0] {
        VEC_NONE  = 2'b00,
        VEC_RESET = 2'b01,
        VEC_NMI   = 2'b10,
        VEC_IRQ   = 2'b11
    } vec_e;

    logic            adv;
    logic            nmi_s;
    logic            nmi_fall;
    stctl_e          sc;

    logic [7:0]      ir_q, ir_d;
    logic [MC_W-1:0] mc_q, mc_d;
    logic            opf_q, opf_d;
    logic            int_act_q, int_act_d;
    vec_e            vec_q, vec_d;
    logic            wait_q, wait_d;
    logic            stop_q, stop_d;
    logic            ovf_q, ovf_d;
    logic            nmi_pend_q, nmi_pend_d;
    logic            nmi_hist_q;
    logic            lat_nmi_q, lat_nmi_d;
    logic            lat_irq_q, lat_irq_d;

    logic            do_last;
    logic            nmi_clr;
    logic [1:0]      step;
    logic [MC_W:0]   mc_sum;

    generate
        if (NMI_SYNC) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) sync_q <= 2'b11;
                else     sync_q <= {sync_q[0], NMI_N};
            end
            assign nmi_s = sync_q[1];
        end else begin : g_nosync
            assign nmi_s = NMI_N;
        end
    endgenerate

    assign adv      = CE & RDY;
    assign nmi_fall = nmi_hist_q & ~nmi_s;
    assign sc       = stctl_e'(STATE_CTRL);

    always_comb begin
        ir_d      = ir_q;
        mc_d      = mc_q;
        opf_d     = opf_q;
        int_act_d = int_act_q;
        vec_d     = vec_q;
        wait_d    = wait_q;
        stop_d    = stop_q;
        ovf_d     = ovf_q;
        lat_nmi_d = lat_nmi_q;
        lat_irq_d = lat_irq_q;
        do_last   = 1'b0;
        nmi_clr   = 1'b0;
        step      = 2'd0;
        mc_sum    = '0;
        if (adv && !stop_q) begin
            if (opf_q) begin
                opf_d = 1'b0;
                mc_d  = {{(MC_W-1){1'b0}}, 1'b1};
                if (lat_nmi_q) begin
                    ir_d      = '0;
                    int_act_d = 1'b1;
                    vec_d     = VEC_NMI;
                    nmi_clr   = 1'b1;
                end else if (lat_irq_q) begin
                    ir_d      = '0;
                    int_act_d = 1'b1;
                    vec_d     = VEC_IRQ;
                end else begin
                    ir_d      = D_IN;
                    int_act_d = 1'b0;
                    vec_d     = VEC_NONE;
                end
            end else if (wait_q) begin
                if (nmi_pend_q || !IRQ_N) begin
                    wait_d  = 1'b0;
                    do_last = 1'b1;
                end
            end else begin
                case (sc)
                    SC_NEXT:    step = 2'd1;
                    SC_LAST:    do_last = 1'b1;
                    SC_SKIP_M8: step = M_FLAG  ? 2'd2 : 2'd1;
                    SC_SKIP_X8: step = X_FLAG  ? 2'd2 : 2'd1;
                    SC_SKIP_DL: step = DL_ZERO ? 2'd2 : 2'd1;
                    SC_BRANCH: begin
                        if (BR_TAKEN) step = 2'd1;
                        else          do_last = 1'b1;
                    end
                    SC_WAIT:    wait_d = 1'b1;
                    SC_STOP:    stop_d = 1'b1;
                endcase
                // One extra bit on the sum catches advancing past all-ones for saturation.
                mc_sum = {1'b0, mc_q} + {{(MC_W-1){1'b0}}, step};
                if (step != 2'd0) begin
                    if (mc_sum[MC_W]) begin
                        mc_d  = '1;
                        ovf_d = 1'b1;
                    end else begin
                        mc_d  = mc_sum[MC_W-1:0];
                    end
                end
            end
            if (do_last) begin
                mc_d      = '0;
                opf_d     = 1'b1;
                lat_nmi_d = nmi_pend_q;
                lat_irq_d = !nmi_pend_q && !IRQ_N && !I_FLAG;
            end
        end
        // A fresh edge arriving on the cycle the NMI is taken must not be lost.
        nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir_q       <= '0;
            mc_q       <= '0;
            opf_q      <= 1'b0;
            int_act_q  <= 1'b1;
            vec_q      <= VEC_RESET;
            wait_q     <= 1'b0;
            stop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_hist_q <= 1'b1;
            lat_nmi_q  <= 1'b0;
            lat_irq_q  <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            mc_q       <= mc_d;
            opf_q      <= opf_d;
            int_act_q  <= int_act_d;
            vec_q      <= vec_d;
            wait_q     <= wait_d;
            stop_q     <= stop_d;
            ovf_q      <= ovf_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_hist_q <= nmi_s;
            lat_nmi_q  <= lat_nmi_d;
            lat_irq_q  <= lat_irq_d;
        end
    end

    assign IR      = ir_q;
    assign MC      = mc_q;
    assign OPFETCH = opf_q;
    assign INT_ACT = int_act_q;
    assign VEC_SEL = vec_q;
    assign WAIT_ST = wait_q;
    assign STOP_ST = stop_q;
    assign MC_OVF  = ovf_q;

endmodule

// File: doc/p65c816_seq_ctrl.md
Name: p65c816_seq_ctrl

Overview:
Instruction-register and micro-cycle sequencer for the 65C816 core. It sits directly upstream of the microcode ROM. It drives {IR, MC} as the ROM address. It consumes the 3-bit state-control field of the microinstruction the ROM returns, and uses it to pick the next micro-cycle. It also owns opcode-fetch timing, interrupt/reset injection, and the WAI/STP hold states.

Parameters:
MC_W, 4, micro-cycle counter width
NMI_SYNC, 1, 1 = NMI_N passes through a 2-flop synchroniser before edge detection; 0 = sampled directly

Ports:
CLK  in  1  core clock
RST  in  1  asynchronous, active-high reset
CE  in  1  clock enable; no state changes when 0
RDY  in  1  bus ready; when 0, all state holds (same as CE=0)
STATE_CTRL  in  3  stateCtrl field of the current microinstruction
D_IN  in  8  data bus (opcode byte during fetch)
M_FLAG  in  1  P.M (1 = 8-bit accumulator/memory)
X_FLAG  in  1  P.X (1 = 8-bit index)
I_FLAG  in  1  P.I (IRQ mask)
DL_ZERO  in  1  D[7:0]==0
BR_TAKEN  in  1  branch condition true
NMI_N  in  1  NMI, active low, falling-edge triggered
IRQ_N  in  1  IRQ, active low, level
IR  out  8  instruction register
MC  out  MC_W  micro-cycle number
OPFETCH  out  1  current cycle is the opcode fetch
INT_ACT  out  1  current instruction is an injected interrupt/reset
VEC_SEL  out  2  00 none/BRK, 01 RESET, 10 NMI, 11 IRQ
WAIT_ST  out  1  in WAI hold
STOP_ST  out  1  in STP hold
MC_OVF  out  1  sticky: MC tried to advance past all-ones

Behaviour:
- Advance condition: adv = CE & RDY. All register updates below happen only on adv.
- Reset (async, RST=1) values:
  - IR=8'h00, MC=0, OPFETCH=0, INT_ACT=1, VEC_SEL=01.
  - WAIT_ST=0, STOP_ST=0, MC_OVF=0, NMI pending=0, NMI edge history=1.
- After reset release, the core executes the BRK-form sequence using the RESET vector. MC starts at 0 and no opcode is fetched first.
- STATE_CTRL decode. The next MC is computed on each adv cycle:
  - 000 NEXT: MC+1.
  - 001 LAST: MC<=0, OPFETCH<=1 for the next cycle.
  - 010 SKIP_M8: MC+2 if M_FLAG else MC+1.
  - 011 SKIP_X8: MC+2 if X_FLAG else MC+1.
  - 100 SKIP_DL: MC+2 if DL_ZERO else MC+1.
  - 101 BRANCH: MC+1 if BR_TAKEN, else behaves as LAST.
  - 110 WAIT: set WAIT_ST and hold MC.
    - Leave WAIT the first adv cycle where an NMI is pending or IRQ_N=0, regardless of I_FLAG.
    - On leaving, take LAST.
  - 111 STOP: set STOP_ST and hold MC until RST. STATE_CTRL is ignored while STOP_ST=1.
- Overflow: if the computed MC exceeds 2^MC_W-1, MC saturates at all-ones and MC_OVF sets. MC_OVF clears only on reset.
- NMI:
  - A falling edge on the (optionally synchronised) NMI_N sets NMI pending. The edge is detected on every clock, independent of adv.
  - Pending clears when the NMI is taken.
- Interrupt decision, made on the LAST (or BRANCH-not-taken, or WAIT-exit) cycle:
  - take_nmi = NMI pending.
  - else take_irq = ~IRQ_N & ~I_FLAG.
  - The decision is latched for the following fetch cycle.
- Fetch cycle (OPFETCH=1, MC=0), on adv:
  - If an interrupt is latched: IR<=8'h00, INT_ACT<=1, VEC_SEL<=10 (NMI) or 11 (IRQ). NMI wins over IRQ when both are present.
  - Else: IR<=D_IN, INT_ACT<=0, VEC_SEL<=00.
  - MC<=1 and OPFETCH<=0. STATE_CTRL is ignored during the fetch cycle.
- WAI exit:
  - With I_FLAG=1 and IRQ: resume without an interrupt (the next fetch is a normal opcode).
  - With I_FLAG=0 and IRQ: take the IRQ.
- RDY=0 or CE=0 during any state freezes IR, MC, flags and the latched decision. NMI edge capture continues.
- Outputs are registered. MC/IR change one cycle after the adv cycle that decided them.

Test Plan:
- Reset release, STATE_CTRL=000 ×6 then 001 → IR=00, INT_ACT=1, VEC_SEL=01, MC counts 0..6. Next cycle MC=0, OPFETCH=1. With D_IN=A9 on that fetch: IR=A9, INT_ACT=0, MC=1.
- SKIP_M8 at MC=2 with M_FLAG=1 → MC=4; repeat with M_FLAG=0 → MC=3. Same check for SKIP_X8/X_FLAG and SKIP_DL/DL_ZERO.
- BRANCH at MC=1 with BR_TAKEN=0 → next cycle MC=0, OPFETCH=1. With BR_TAKEN=1 → MC=2.
- NMI_N pulse low for 1 cycle mid-instruction, IRQ_N=0, I_FLAG=0, then LAST → fetch loads IR=00 with VEC_SEL=10. Next LAST with IRQ_N still low → VEC_SEL=11.
- WAIT held 20 cycles, then IRQ_N=0 with I_FLAG=1 → WAIT_ST drops, fetch loads D_IN=EA, INT_ACT=0. Then STOP → STOP_ST=1, MC frozen despite NMI, until RST.
- MC=15 with NEXT → MC stays 15, MC_OVF=1. RDY=0 for 3 cycles mid-sequence → MC/IR unchanged, but an NMI edge during the stall is still taken at the next LAST.
